// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions used by both the driver and the capture side.
package hub75_pkg;

  localparam int unsigned RGB_W = 3;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    WAIT_LATCH,
    SHIFT,
    OVERFLOW
  } state_t;

endpackage

// File: rtl/hub75_in_sync.sv
// Two-flop synchronizers for every HUB75 input plus rising-edge strobes
// for the shift clock and latch.
module hub75_in_sync
  import hub75_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             hub75_clk,
  input  logic             hub75_latch,
  input  logic             hub75_OE,
  input  logic [AW-1:0]    hub75_addr,
  input  logic [RGB_W-1:0] hub75_rgb0,
  input  logic [RGB_W-1:0] hub75_rgb1,
  output logic             clk_rise,
  output logic             latch_rise,
  output logic             oe_n_s,
  output logic [AW-1:0]    addr_s,
  output logic [RGB_W-1:0] rgb0_s,
  output logic [RGB_W-1:0] rgb1_s
);

  localparam int unsigned W = 3 + AW + 2 * RGB_W;
  // OE resets to its inactive (high) level so the on counter stays idle.
  localparam logic [W-1:0] RST_V = {3'b001, {(AW + 2 * RGB_W){1'b0}}};

  logic [W-1:0] sync1, sync2;
  logic         prev_clk, prev_latch;
  logic         s_clk, s_latch;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1      <= RST_V;
      sync2      <= RST_V;
      prev_clk   <= 1'b0;
      prev_latch <= 1'b0;
    end else begin
      sync1      <= {hub75_clk, hub75_latch, hub75_OE, hub75_addr, hub75_rgb0, hub75_rgb1};
      sync2      <= sync1;
      prev_clk   <= s_clk;
      prev_latch <= s_latch;
    end
  end

  assign {s_clk, s_latch, oe_n_s, addr_s, rgb0_s, rgb1_s} = sync2;
  assign clk_rise   = s_clk & ~prev_clk;
  assign latch_rise = s_latch & ~prev_latch;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receive-side decoder: rebuilds each shifted row and presents it on
// a valid/ready stream with its scan address and OE-on time.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int unsigned NUM_COLS  = 64,
  parameter int unsigned SCAN_RATE = 32,
  parameter int unsigned ON_CNT_W  = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          hub75_clk,
  input  logic                          hub75_latch,
  input  logic                          hub75_OE,
  input  logic [$clog2(SCAN_RATE)-1:0]  hub75_addr,
  input  logic [RGB_W-1:0]              hub75_rgb0,
  input  logic [RGB_W-1:0]              hub75_rgb1,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [$clog2(SCAN_RATE)-1:0]  row_addr,
  output logic [RGB_W*NUM_COLS-1:0]     row_data0,
  output logic [RGB_W*NUM_COLS-1:0]     row_data1,
  output logic                          row_last,
  output logic [ON_CNT_W-1:0]           row_on_cycles,
  output logic                          err_short,
  output logic                          err_long,
  output logic                          err_overrun
);

  localparam int unsigned AW = $clog2(SCAN_RATE);
  localparam int unsigned CW = $clog2(NUM_COLS + 1);
  localparam int unsigned DW = RGB_W * NUM_COLS;

  logic             clk_rise, latch_rise, oe_n_s;
  logic [AW-1:0]    addr_s;
  logic [RGB_W-1:0] rgb0_s, rgb1_s;

  state_t           state;
  logic [CW-1:0]    col_cnt, cnt_next;
  logic             clk_wr, ovf_now;
  logic [DW-1:0]    shift0, shift1;
  logic [ON_CNT_W-1:0] on_cnt, stage_on;
  logic [AW-1:0]    stage_addr;
  logic             load_pend;

  hub75_in_sync #(.AW(AW)) u_sync (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .hub75_clk   (hub75_clk),
    .hub75_latch (hub75_latch),
    .hub75_OE    (hub75_OE),
    .hub75_addr  (hub75_addr),
    .hub75_rgb0  (hub75_rgb0),
    .hub75_rgb1  (hub75_rgb1),
    .clk_rise    (clk_rise),
    .latch_rise  (latch_rise),
    .oe_n_s      (oe_n_s),
    .addr_s      (addr_s),
    .rgb0_s      (rgb0_s),
    .rgb1_s      (rgb1_s)
  );

  // A clk edge coinciding with a latch edge is folded in first, so the
  // latch decision below always looks at the post-shift count.
  always_comb begin
    clk_wr  = 1'b0;
    ovf_now = (state == OVERFLOW);
    if (state == SHIFT && clk_rise) begin
      if (col_cnt == CW'(NUM_COLS)) ovf_now = 1'b1;
      else                          clk_wr  = 1'b1;
    end
    cnt_next = col_cnt + CW'(clk_wr);
  end

  always_ff @(posedge clk_in) begin
    if (clk_wr) begin
      shift0[RGB_W*col_cnt +: RGB_W] <= rgb0_s;
      shift1[RGB_W*col_cnt +: RGB_W] <= rgb1_s;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= WAIT_LATCH;
      col_cnt    <= '0;
      on_cnt     <= '0;
      stage_on   <= '0;
      stage_addr <= '0;
      load_pend  <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      load_pend <= 1'b0;

      if (latch_rise)                    on_cnt <= '0;
      else if (!oe_n_s && on_cnt != '1) on_cnt <= on_cnt + ON_CNT_W'(1);

      case (state)
        WAIT_LATCH: begin
          if (latch_rise) begin
            state   <= SHIFT;
            col_cnt <= '0;
          end
        end
        SHIFT, OVERFLOW: begin
          if (latch_rise) begin
            state      <= SHIFT;
            col_cnt    <= '0;
            stage_addr <= addr_s;
            stage_on   <= on_cnt;
            if (ovf_now)                         err_long  <= 1'b1;
            else if (cnt_next == CW'(NUM_COLS)) load_pend <= 1'b1;
            else                                 err_short <= 1'b1;
          end else begin
            col_cnt <= cnt_next;
            if (ovf_now) state <= OVERFLOW;
          end
        end
        default: begin
          state   <= WAIT_LATCH;
          col_cnt <= '0;
        end
      endcase
    end
  end

  // Output holding register; a held row is never overwritten.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_valid     <= 1'b0;
      row_addr      <= '0;
      row_data0     <= '0;
      row_data1     <= '0;
      row_last      <= 1'b0;
      row_on_cycles <= '0;
      err_overrun   <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      if (load_pend) begin
        if (row_valid && !row_ready) begin
          err_overrun <= 1'b1;
        end else begin
          row_valid     <= 1'b1;
          row_addr      <= stage_addr;
          row_data0     <= shift0;
          row_data1     <= shift1;
          row_last      <= (stage_addr == AW'(SCAN_RATE - 1));
          row_on_cycles <= stage_on;
        end
      end else if (row_valid && row_ready) begin
        row_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hub75_capture.sv
// Randomized bench for hub75_capture, checked against a row-level model.
module tb_hub75_capture;

  localparam int NC = 64;
  localparam int DW = 3 * NC;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          hub75_clk = 1'b0;
  logic          hub75_latch = 1'b0;
  logic          hub75_OE = 1'b1;
  logic [4:0]    hub75_addr = '0;
  logic [2:0]    hub75_rgb0 = '0;
  logic [2:0]    hub75_rgb1 = '0;
  logic          row_ready = 1'b0;
  logic          row_valid, row_last, err_short, err_long, err_overrun;
  logic [4:0]    row_addr;
  logic [DW-1:0] row_data0, row_data1;
  logic [15:0]   row_on_cycles;

  hub75_capture #(.NUM_COLS(64), .SCAN_RATE(32), .ON_CNT_W(16)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hub75_clk     (hub75_clk),
    .hub75_latch   (hub75_latch),
    .hub75_OE      (hub75_OE),
    .hub75_addr    (hub75_addr),
    .hub75_rgb0    (hub75_rgb0),
    .hub75_rgb1    (hub75_rgb1),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_addr      (row_addr),
    .row_data0     (row_data0),
    .row_data1     (row_data1),
    .row_last      (row_last),
    .row_on_cycles (row_on_cycles),
    .err_short     (err_short),
    .err_long      (err_long),
    .err_overrun   (err_overrun)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Row-level model: alignment, the held row and what it should contain.
  bit            m_aligned = 1'b0;
  bit            m_valid   = 1'b0;
  logic [4:0]    m_addr    = '0;
  logic [DW-1:0] m_d0      = '0;
  logic [DW-1:0] m_d1      = '0;
  int            m_on      = 0;

  // Observations from the latest latch window.
  int            o_short, o_long, o_ovr, o_valid;
  logic [4:0]    s_addr;
  logic [DW-1:0] s_d0, s_d1;
  logic          s_last;
  logic [15:0]   s_on;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic shift_pixels(input int n, input bit pattern,
                              output logic [DW-1:0] d0, output logic [DW-1:0] d1);
    logic [2:0] px0, px1;
    d0 = '0;
    d1 = '0;
    for (int k = 0; k < n; k++) begin
      if (pattern) begin
        px0 = 3'(k % 8);
        px1 = 3'(7 - (k % 8));
      end else begin
        px0 = 3'($urandom);
        px1 = 3'($urandom);
      end
      if (k < NC) begin
        d0[3*k +: 3] = px0;
        d1[3*k +: 3] = px1;
      end
      hub75_rgb0 = px0;
      hub75_rgb1 = px1;
      hub75_clk  = 1'b0;
      repeat ($urandom_range(3, 2)) tick();
      hub75_clk = 1'b1;
      repeat ($urandom_range(3, 2)) tick();
    end
    hub75_clk = 1'b0;
    repeat (2) tick();
  endtask

  task automatic latch_observe(input logic [4:0] addr);
    o_short = 0; o_long = 0; o_ovr = 0; o_valid = 0;
    hub75_addr  = addr;
    hub75_latch = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) hub75_latch = 1'b0;
      if (err_short)   o_short++;
      if (err_long)    o_long++;
      if (err_overrun) o_ovr++;
      if (row_valid) begin
        o_valid++;
        s_addr = row_addr;
        s_d0   = row_data0;
        s_d1   = row_data1;
        s_last = row_last;
        s_on   = row_on_cycles;
      end
    end
  endtask

  task automatic send_row(input int n, input logic [4:0] addr, input int on_len, input bit pattern);
    logic [DW-1:0] d0, d1;
    bit e_short, e_long, e_ovr, e_load;
    e_short = 0; e_long = 0; e_ovr = 0; e_load = 0;
    if (row_ready) m_valid = 1'b0;
    shift_pixels(n, pattern, d0, d1);
    if (on_len > 0) begin
      hub75_OE = 1'b0;
      repeat (on_len) tick();
      hub75_OE = 1'b1;
      repeat (2) tick();
    end
    if (!m_aligned) m_aligned = 1'b1;
    else if (n < NC) e_short = 1'b1;
    else if (n > NC) e_long = 1'b1;
    else if (m_valid && !row_ready) e_ovr = 1'b1;
    else begin
      e_load  = 1'b1;
      m_valid = 1'b1;
      m_addr  = addr;
      m_d0    = d0;
      m_d1    = d1;
      m_on    = (on_len > 65535) ? 65535 : on_len;
    end
    latch_observe(addr);
    check_eq("err_short_cycles", o_short, e_short);
    check_eq("err_long_cycles", o_long, e_long);
    check_eq("err_overrun_cycles", o_ovr, e_ovr);
    if (row_ready) check_eq("row_valid_cycles", o_valid, e_load);
    else           check_eq("row_valid_held", row_valid, m_valid);
    if (m_valid) begin
      check_eq("row_addr", s_addr, m_addr);
      check_eq("row_data0", s_d0, m_d0);
      check_eq("row_data1", s_d1, m_d1);
      check_eq("row_last", s_last, (m_addr == 5'd31));
      check_eq("row_on_cycles", s_on, m_on);
    end
    if (row_ready) m_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, row_valid, 0);
    check_eq({tag, "_addr"}, row_addr, 0);
    check_eq({tag, "_data0"}, row_data0, 0);
    check_eq({tag, "_data1"}, row_data1, 0);
    check_eq({tag, "_last"}, row_last, 0);
    check_eq({tag, "_on"}, row_on_cycles, 0);
    check_eq({tag, "_errs"}, {err_short, err_long, err_overrun}, 0);
  endtask

  initial begin
    logic [DW-1:0] d0, d1;
    int lens[8] = '{64, 64, 64, 63, 65, 64, 1, 64};

    #2;
    check_all_zero("reset");
    repeat (3) tick();
    rst_in = 1'b0;
    repeat (2) tick();

    // Unaligned first row is discarded, then the fixed pattern row.
    row_ready = 1'b1;
    send_row(64, 5'd5, 0, 1'b0);
    row_ready = 1'b0;
    send_row(64, 5'd5, 0, 1'b1);
    check_eq("pattern_col0", s_d0[2:0], 3'd0);
    check_eq("pattern_col63", s_d0[DW-1 -: 3], 3'd7);
    row_ready = 1'b1;
    tick();
    check_eq("accept_drop", row_valid, 0);
    m_valid = 1'b0;

    send_row(64, 5'd31, 0, 1'b0);
    send_row(40, 5'd2, 0, 1'b0);
    send_row(70, 5'd2, 0, 1'b0);
    send_row(64, 5'd2, 0, 1'b0);

    // Overrun: second row dropped while the first is held.
    row_ready = 1'b0;
    send_row(64, 5'd3, 0, 1'b0);
    send_row(64, 5'd4, 0, 1'b0);
    check_eq("overrun_keep_addr", row_addr, 5'd3);
    row_ready = 1'b1;
    tick();
    check_eq("overrun_accept_drop", row_valid, 0);
    m_valid = 1'b0;

    send_row(64, 5'd9, 500, 1'b0);
    send_row(64, 5'd10, 70000, 1'b0);

    for (int r = 0; r < 12; r++) begin
      row_ready = 1'($urandom_range(1, 0));
      send_row(lens[$urandom_range(7, 0)], 5'($urandom), $urandom_range(300, 0), 1'b0);
    end

    // Asynchronous reset in the middle of a row while a row is held.
    row_ready = 1'b0;
    if (m_valid) begin
      row_ready = 1'b1;
      tick();
      m_valid = 1'b0;
      row_ready = 1'b0;
    end
    send_row(64, 5'd12, 0, 1'b0);
    shift_pixels(30, 1'b0, d0, d1);
    rst_in = 1'b1;
    #1;
    check_all_zero("midrow_reset");
    repeat (3) tick();
    rst_in = 1'b0;
    m_aligned = 1'b0;
    m_valid   = 1'b0;
    repeat (2) tick();
    send_row(0, 5'd7, 0, 1'b0);
    row_ready = 1'b1;
    send_row(64, 5'd8, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
